typing_session_ctrl: RTL and testbench

- Session controller for the typing tutor. It drives the seconds timer's enable and clear, and consumes that timer's elapsed-seconds count.
- It counts correct and incorrect keystrokes from the key-compare stage and ends the session when the time limit is reached.
- It latches the final score for the display stage.

---
 rtl/typing_pkg.sv | 17 +
 rtl/typing_session_ctrl_sat_counter.sv | 25 ++
 rtl/typing_session_ctrl.sv | 130 +++++++++++++
 tb/tb_typing_session_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/typing_pkg.sv
// Shared types, default sizes and helpers for the typing tutor datapath.
package typing_pkg;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  localparam int unsigned DEF_TIME_W     = 4;
  localparam int unsigned DEF_TIME_LIMIT = 15;
  localparam int unsigned DEF_CNT_W      = 8;

  // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/typing_session_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter
  import typing_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= CNT_W'(sat_inc(32'(count), CNT_W));
    end
  end

  assign sat = &count;

endmodule

// File: rtl/typing_session_ctrl.sv
// Typing session controller: drives the seconds timer, counts keystrokes, latches the score.
// Optional longest-correct-streak tracking is compiled in with `define TYPING_STREAK_EN.
module typing_session_ctrl
  import typing_pkg::*;
#(
  parameter int unsigned TIME_W     = DEF_TIME_W,
  parameter int unsigned TIME_LIMIT = DEF_TIME_LIMIT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              key_valid,
  input  logic              key_correct,
  input  logic [TIME_W-1:0] elapsed_s,
  output logic              timer_clear,
  output logic              timer_enable,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  correct_cnt,
  output logic [CNT_W-1:0]  error_cnt,
  output logic [CNT_W-1:0]  score
`ifdef TYPING_STREAK_EN
  ,
  output logic [CNT_W-1:0]  best_streak
`endif
);

  state_t state;
  logic   limit_hit;
  logic   arm_entry;
  logic   key_ok;
  logic   correct_sat;
  logic   error_sat;

  assign limit_hit = (elapsed_s >= TIME_W'(TIME_LIMIT));
  // Results are cleared on the edge into ARM so they already read zero during ARM.
  assign arm_entry = start && ((state == IDLE) || (state == DONE));
  // The key arriving with the limit sample is dropped.
  assign key_ok    = (state == RUN) && key_valid && !limit_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer_clear  <= 1'b0;
      timer_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= ARM;
            timer_clear  <= 1'b1;
            timer_enable <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        ARM: begin
          state        <= RUN;
          timer_clear  <= 1'b0;
          timer_enable <= 1'b1;
        end
        RUN: begin
          if (limit_hit) begin
            state        <= DONE;
            timer_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          timer_clear  <= 1'b0;
          timer_enable <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_correct_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (arm_entry),
    .inc   (key_ok && key_correct && !correct_sat),
    .count (correct_cnt),
    .sat   (correct_sat)
  );

  sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (arm_entry),
    .inc   (key_ok && !key_correct && !error_sat),
    .count (error_cnt),
    .sat   (error_sat)
  );

  assign score = (correct_cnt > error_cnt) ? (correct_cnt - error_cnt) : '0;

`ifdef TYPING_STREAK_EN
  logic [CNT_W-1:0] cur_streak;
  logic [CNT_W-1:0] next_streak;
  logic             streak_sat;

  // An incorrect key restarts the run of correct keys.
  sat_counter #(.CNT_W(CNT_W)) u_cur_streak (
    .clk   (clk),
    .reset (reset),
    .clear (arm_entry || (key_ok && !key_correct)),
    .inc   (key_ok && key_correct && !streak_sat),
    .count (cur_streak),
    .sat   (streak_sat)
  );

  assign next_streak = CNT_W'(sat_inc(32'(cur_streak), CNT_W));

  always_ff @(posedge clk) begin
    if (reset || arm_entry) begin
      best_streak <= '0;
    end else if (key_ok && key_correct && (next_streak > best_streak)) begin
      best_streak <= next_streak;
    end
  end
`endif

endmodule

// File: tb/tb_typing_session_ctrl.sv
// Directed bench for typing_session_ctrl; a CNT_W=4 copy shares the stimulus for saturation.
`timescale 1ns/1ps
module tb_typing_session_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       key_valid;
  logic       key_correct;
  logic [3:0] elapsed_s;

  logic       timer_clear, timer_enable, busy, done;
  logic [7:0] correct_cnt, error_cnt, score;
  logic       s_timer_clear, s_timer_enable, s_busy, s_done;
  logic [3:0] s_correct_cnt, s_error_cnt, s_score;
`ifdef TYPING_STREAK_EN
  logic [7:0] best_streak;
  logic [3:0] s_best_streak;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  typing_session_ctrl #(.TIME_W(4), .TIME_LIMIT(15), .CNT_W(8)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key_valid    (key_valid),
    .key_correct  (key_correct),
    .elapsed_s    (elapsed_s),
    .timer_clear  (timer_clear),
    .timer_enable (timer_enable),
    .busy         (busy),
    .done         (done),
    .correct_cnt  (correct_cnt),
    .error_cnt    (error_cnt),
    .score        (score)
`ifdef TYPING_STREAK_EN
    ,
    .best_streak  (best_streak)
`endif
  );

  typing_session_ctrl #(.TIME_W(4), .TIME_LIMIT(15), .CNT_W(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key_valid    (key_valid),
    .key_correct  (key_correct),
    .elapsed_s    (elapsed_s),
    .timer_clear  (s_timer_clear),
    .timer_enable (s_timer_enable),
    .busy         (s_busy),
    .done         (s_done),
    .correct_cnt  (s_correct_cnt),
    .error_cnt    (s_error_cnt),
    .score        (s_score)
`ifdef TYPING_STREAK_EN
    ,
    .best_streak  (s_best_streak)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_keys(input int nc, input int ne);
    for (int i = 0; i < nc; i++) begin
      key_valid = 1'b1; key_correct = 1'b1; tick();
    end
    for (int i = 0; i < ne; i++) begin
      key_valid = 1'b1; key_correct = 1'b0; tick();
    end
    key_valid = 1'b0; key_correct = 1'b0;
  endtask

  task automatic start_session();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  // Hit the limit, optionally with a (dropped) correct key in the same cycle.
  task automatic end_session(input logic with_key);
    elapsed_s = 4'd15; key_valid = with_key; key_correct = 1'b1; tick();
    elapsed_s = 4'd0;  key_valid = 1'b0;     key_correct = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; key_valid = 1'b0; key_correct = 1'b0; elapsed_s = '0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_valid = i[0]; key_correct = 1'b1; tick();
    end
    key_valid = 1'b0;
    n_checks++;
    if ({timer_clear, timer_enable, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {timer_clear, timer_enable, busy, done});
    end
    n_checks++;
    if ({correct_cnt, error_cnt, score} !== 24'd0) begin
      n_fail++; $display("FAIL reset_counts: got c=%0d e=%0d s=%0d expected 0 0 0", correct_cnt, error_cnt, score);
    end
  endtask

  task automatic test_idle_start_key();
    start = 1'b1; key_valid = 1'b1; key_correct = 1'b1; tick();
    start = 1'b0; key_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || timer_clear !== 1'b1 || correct_cnt !== 8'd0) begin
      n_fail++; $display("FAIL idle_start_key: got busy=%b clr=%b c=%0d expected 1 1 0", busy, timer_clear, correct_cnt);
    end
    tick();
    end_session(1'b0);
  endtask

  task automatic test_normal();
    start = 1'b1; tick();
    start = 1'b0;
    n_checks++;
    if ({timer_clear, timer_enable, busy, done} !== 4'b1010) begin
      n_fail++; $display("FAIL arm_outputs: got %b expected 1010", {timer_clear, timer_enable, busy, done});
    end
    tick();
    n_checks++;
    if ({timer_clear, timer_enable, busy, done} !== 4'b0110) begin
      n_fail++; $display("FAIL run_outputs: got %b expected 0110", {timer_clear, timer_enable, busy, done});
    end
    send_keys(7, 3);
    n_checks++;
    if (correct_cnt !== 8'd7 || error_cnt !== 8'd3 || done !== 1'b0) begin
      n_fail++; $display("FAIL run_counts: got c=%0d e=%0d done=%b expected 7 3 0", correct_cnt, error_cnt, done);
    end
    end_session(1'b0);
    n_checks++;
    if ({timer_clear, timer_enable, busy, done} !== 4'b0001) begin
      n_fail++; $display("FAIL done_outputs: got %b expected 0001", {timer_clear, timer_enable, busy, done});
    end
    n_checks++;
    if (correct_cnt !== 8'd7 || error_cnt !== 8'd3 || score !== 8'd4) begin
      n_fail++; $display("FAIL done_score: got c=%0d e=%0d s=%0d expected 7 3 4", correct_cnt, error_cnt, score);
    end
    send_keys(2, 2);
    n_checks++;
    if (correct_cnt !== 8'd7 || error_cnt !== 8'd3 || done !== 1'b1) begin
      n_fail++; $display("FAIL done_hold: got c=%0d e=%0d done=%b expected 7 3 1", correct_cnt, error_cnt, done);
    end
  endtask

  task automatic test_floor_boundary();
    start = 1'b1; tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || correct_cnt !== 8'd0 || error_cnt !== 8'd0) begin
      n_fail++; $display("FAIL restart_clear: got done=%b busy=%b c=%0d e=%0d expected 0 1 0 0", done, busy, correct_cnt, error_cnt);
    end
    tick();
    send_keys(2, 5);
    end_session(1'b1);
    n_checks++;
    if (correct_cnt !== 8'd2 || error_cnt !== 8'd5 || score !== 8'd0) begin
      n_fail++; $display("FAIL floor_boundary: got c=%0d e=%0d s=%0d expected 2 5 0", correct_cnt, error_cnt, score);
    end
  endtask

  task automatic test_saturation();
    start_session();
    send_keys(20, 0);
    end_session(1'b0);
    n_checks++;
    if (s_correct_cnt !== 4'd15 || s_score !== 4'd15 || s_done !== 1'b1) begin
      n_fail++; $display("FAIL sat_w4: got c=%0d s=%0d done=%b expected 15 15 1", s_correct_cnt, s_score, s_done);
    end
    n_checks++;
    if (correct_cnt !== 8'd20) begin
      n_fail++; $display("FAIL sat_w8: got c=%0d expected 20", correct_cnt);
    end
  endtask

  task automatic test_abort();
    start_session();
    send_keys(3, 1);
    reset = 1'b1; tick();
    reset = 1'b0;
    n_checks++;
    if ({timer_clear, timer_enable, busy, done} !== 4'b0000 || correct_cnt !== 8'd0 || error_cnt !== 8'd0) begin
      n_fail++; $display("FAIL abort: got ctrl=%b c=%0d e=%0d expected 0000 0 0", {timer_clear, timer_enable, busy, done}, correct_cnt, error_cnt);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || timer_clear !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b clr=%b expected 0 0", busy, timer_clear);
    end
  endtask

`ifdef TYPING_STREAK_EN
  task automatic test_streak();
    start_session();
    send_keys(3, 1);
    send_keys(2, 0);
    n_checks++;
    if (best_streak !== 8'd3 || u_dut.cur_streak !== 8'd2) begin
      n_fail++; $display("FAIL streak: got best=%0d cur=%0d expected 3 2", best_streak, u_dut.cur_streak);
    end
    end_session(1'b1);
    n_checks++;
    if (best_streak !== 8'd3 || done !== 1'b1) begin
      n_fail++; $display("FAIL streak_hold: got best=%0d done=%b expected 3 1", best_streak, done);
    end
    start = 1'b1; tick();
    start = 1'b0;
    n_checks++;
    if (best_streak !== 8'd0) begin
      n_fail++; $display("FAIL streak_clear: got %0d expected 0", best_streak);
    end
    tick();
    end_session(1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_idle_start_key();
    test_normal();
    test_floor_boundary();
    test_saturation();
    test_abort();
`ifdef TYPING_STREAK_EN
    test_streak();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
